data_mem_responder: RTL

//   Responder (slave) end of the CPU data-memory request interface: accepts one load/store

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/data_mem_responder_array.sv | 34 +++
 rtl/data_mem_responder.sv | 103 ++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default geometry/latency and the latency counter width.
// Optional misaligned-access checking is selected by the DMEM_ALIGN_CHECK_EN macro (see top).
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEPTH_DEF   = 32;
  localparam int LATENCY_DEF = 3;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory request bus: one request handshake plus a single-cycle completion.
// The CPU side drives the request fields; the responder drives ready/ack/rdata/err.
// Request fields are only meaningful while ready_o is high.
interface data_mem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, ack_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, ack_o, rdata_o, err_o
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// DEPTH x 32 storage: synchronous write, registered read.
// The read register is the load-data output; it only changes on rd_en_i and resets to 0.
// Contents are not reset.
module data_mem_array #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Store path: write the selected word when the responder commits a store.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[addr_i] <= wdata_i;
  end

  // Load path: capture the word (or zero for a rejected access) and hold it.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (rd_en_i) rdata_q <= rd_zero_i ? 32'h0 : mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory bus: one request at a time, fixed LATENCY to ack.
// Latency: ack_o LATENCY cycles after acceptance; next accept possible LATENCY+1 cycles later.
// Backpressure: ready_o high only in IDLE; inputs are ignored otherwise. Macro: DMEM_ALIGN_CHECK_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q;
  logic [AW-1:0]    word_q;
  logic [31:0]      wdata_q;
  logic             mis_q;
  logic             err_q;
  logic             accept;
  logic             enter_resp;

  assign accept = (state_q == IDLE) && bus.req_i;

  // Next-state and counter: IDLE -> WAIT (counts down) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req_i) begin
          state_d = (LATENCY == 1) ? RESP : WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at acceptance; fields are held for the whole access.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= bus.we_i;
      word_q  <= bus.addr_i[2 +: AW];
      wdata_q <= bus.wdata_i;
      mis_q   <= ALIGN_EN && (bus.addr_i[1:0] != 2'b00);
    end
  end

  // The array access happens on the edge into RESP; reset blocks a pending commit.
  assign enter_resp = !rst_i && (state_d == RESP) && (state_q != RESP);

  // Error flag follows each completed access and is qualified by ack_o.
  always_ff @(posedge clk_i) begin
    if (rst_i)           err_q <= 1'b0;
    else if (enter_resp) err_q <= mis_q;
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (enter_resp && we_q && !mis_q),
    .rd_en_i   (enter_resp && (!we_q || mis_q)),
    .rd_zero_i (mis_q),
    .addr_i    (word_q),
    .wdata_i   (wdata_q),
    .rdata_o   (bus.rdata_o)
  );

  assign bus.ready_o = (state_q == IDLE);
  assign bus.ack_o   = (state_q == RESP);
  assign bus.err_o   = (state_q == RESP) && err_q;

endmodule
